// File: rtl/nonrestoring_divider.sv
// Multi-cycle non-restoring divider: one shared add/subtract slice per step, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands with truncating-division results.
module nonrestoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    step;
  logic [WIDTH:0]   p_reg, d_reg;
  logic [WIDTH-1:0] a_reg;
  logic             mode;
  logic [WIDTH:0]   slice_a, slice_sum;
  logic [WIDTH-1:0] rem_fix, q_final, r_final;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

`ifdef DIVIDER_SIGNED_EN
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_raw;

  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + ONE_W) : dividend;
    dvs_mag = divisor[WIDTH-1] ? (~divisor + ONE_W) : divisor;
  end
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (step == CW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  // The single slice subtracts (mode=1) or adds D; in FIX it is reused for the restoring add.
  always_comb begin
    mode    = 1'b0;
    slice_a = p_reg;
    if (state == RUN) begin
      mode    = ~p_reg[WIDTH];
      slice_a = {p_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    end
    slice_sum = slice_a + (d_reg ^ {(WIDTH + 1){mode}}) + {{WIDTH{1'b0}}, mode};
    rem_fix   = p_reg[WIDTH] ? slice_sum[WIDTH-1:0] : p_reg[WIDTH-1:0];
  end

`ifdef DIVIDER_SIGNED_EN
  // Magnitude core result gets its signs restored; a zero divisor overrides everything.
  always_comb begin
    if (div_by_zero) begin
      q_final = '1;
      r_final = dvd_raw;
    end else begin
      q_final = (dvd_neg ^ dvs_neg) ? (~a_reg + ONE_W) : a_reg;
      r_final = dvd_neg ? (~rem_fix + ONE_W) : rem_fix;
    end
  end
`else
  always_comb begin
    q_final = a_reg;
    r_final = rem_fix;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      p_reg       <= '0;
      d_reg       <= '0;
      step        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      dvd_raw     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg       <= dvd_mag;
            d_reg       <= {1'b0, dvs_mag};
            p_reg       <= '0;
            step        <= '0;
            div_by_zero <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
            dvd_neg     <= dividend[WIDTH-1];
            dvs_neg     <= divisor[WIDTH-1];
            dvd_raw     <= dividend;
`endif
          end
        end
        RUN: begin
          p_reg <= slice_sum;
          a_reg <= {a_reg[WIDTH-2:0], ~slice_sum[WIDTH]};
          step  <= step + CW'(1);
        end
        FIX: begin
          quotient  <= q_final;
          remainder <= r_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider: driver pushes expected results, negedge monitor checks them.
// Follows DIVIDER_SIGNED_EN to choose the signed or unsigned reference.
module tb_nonrestoring_divider;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           issue;
  } exp_t;

  logic         clk, rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t         sb[$];
  exp_t         last_exp;
  int           n_checks = 0;
  int           n_fail = 0;
  int           cycle_count = 0;
  int           busy_cnt = 0;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_count++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Plain arithmetic reference; C-style truncating division matches the signed rules.
  task automatic ref_model(input logic [W-1:0] n, input logic [W-1:0] d,
                           output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIVIDER_SIGNED_EN
    int sn, sd, iq, ir;
    sn = $signed(n);
    sd = $signed(d);
    if (d == '0) begin
      q = '1;
      r = n;
    end else begin
      iq = sn / sd;
      ir = sn % sd;
      q  = iq[W-1:0];
      r  = ir[W-1:0];
    end
`else
    if (d == '0) begin
      q = '1;
      r = n;
    end else begin
      q = n / d;
      r = n % d;
    end
`endif
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy || done) checkOutput("idle_timeout", {31'd0, busy | done}, 32'd0);
  endtask

  // Issues one start pulse and pushes the expected response before it is accepted.
  task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] d,
                               input logic [W-1:0] eq, input logic [W-1:0] er);
    exp_t e;
    wait_idle();
    e.q = eq;
    e.r = er;
    e.dz = (d == '0);
    e.issue = cycle_count;
    sb.push_back(e);
    last_exp = e;
    dividend = n;
    divisor = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_model(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [W-1:0] q, r;
    ref_model(n, d, q, r);
    applyStimulus(n, d, q, r);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy || done) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", {28'd0, quotient}, {28'd0, e.q});
          checkOutput("remainder", {28'd0, remainder}, {28'd0, e.r});
          checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
          checkOutput("latency", cycle_count - e.issue, W + 2);
          checkOutput("busy_cycles", busy_cnt, W + 1);
        end
        busy_cnt = 0;
      end
    end
  end

  // Directed cases: operand pair and the hand-computed result.
  logic [W-1:0] dir_n[5], dir_d[5], dir_q[5], dir_r[5];

  initial begin
`ifdef DIVIDER_SIGNED_EN
    dir_n = '{4'h9, 4'h7, 4'h8, 4'h9, 4'h0};
    dir_d = '{4'h2, 4'hE, 4'hF, 4'h0, 4'h5};
    dir_q = '{4'hD, 4'hD, 4'h8, 4'hF, 4'h0};
    dir_r = '{4'hF, 4'h1, 4'h0, 4'h9, 4'h0};
`else
    dir_n = '{4'd13, 4'd15, 4'd5, 4'd0, 4'd9};
    dir_d = '{4'd3,  4'd1,  4'd7, 4'd5, 4'd0};
    dir_q = '{4'd4,  4'd15, 4'd0, 4'd0, 4'hF};
    dir_r = '{4'd1,  4'd0,  4'd5, 4'd0, 4'd9};
`endif
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", {28'd0, quotient}, 32'd0);
    checkOutput("reset_remainder", {28'd0, remainder}, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(dir_n[i], dir_d[i], dir_q[i], dir_r[i]);
    wait_drain();

    // Results must stay put while idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("hold_quotient", {28'd0, quotient}, {28'd0, last_exp.q});
    checkOutput("hold_remainder", {28'd0, remainder}, {28'd0, last_exp.r});

    // Extra starts during a run are ignored.
    apply_model(4'd13, 4'd3);
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd2; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;

    // Abort mid-run with reset, then confirm a fresh division still works.
    apply_model(4'd14, 4'd4);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quotient", {28'd0, quotient}, 32'd0);
    checkOutput("abort_remainder", {28'd0, remainder}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    apply_model(4'd11, 4'd2);
    wait_drain();

    // Exhaustive sweep, then randomized back-to-back traffic.
    for (int n = 0; n < 16; n++)
      for (int d = 0; d < 16; d++)
        apply_model(W'(n), W'(d));
    for (int i = 0; i < 60; i++)
      apply_model(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
